// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared LSU types, funct3 width and the size-to-byte-mask helper.
package rv32i_pkg;
  localparam int FUNCT3_WIDTH = 3;
  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_D = 2'b11} size_e;
  typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_e;
  function automatic logic [7:0] size_mask(input size_e size);
    return size == SZ_B ? 8'h01 : size == SZ_H ? 8'h03 : size == SZ_W ? 8'h0f : 8'hff;
  endfunction
endpackage

// File: rtl/lsu_lane_shifter.sv
// lsu_lane_shifter: store lane shift/strobe for two beats and load extract with sign/zero extension.
module lsu_lane_shifter
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]                 size,
  input  logic                       zext,
  input  logic [$clog2(XLEN/8)-1:0]  offset,
  input  logic [XLEN-1:0]            wdata,
  input  logic [XLEN-1:0]            rdata0,
  input  logic [XLEN-1:0]            rdata1,
  output logic [XLEN/8-1:0]          strb0,
  output logic [XLEN/8-1:0]          strb1,
  output logic [XLEN-1:0]            wdata0,
  output logic [XLEN-1:0]            wdata1,
  output logic [XLEN-1:0]            load
);
  localparam int STRB_W = XLEN/8;
  logic [2*STRB_W-1:0] strb;
  logic [2*XLEN-1:0] wshift;
  logic [XLEN-1:0] raw, pack;
  logic signed [XLEN-1:0] sext;
  logic [6:0] bits, shamt;
  always_comb begin
    strb = (2*STRB_W)'(size_mask(size_e'(size))) << offset;
    wshift = {{XLEN{1'b0}}, wdata} << {offset, 3'b000};
    raw = XLEN'({rdata1, rdata0} >> {offset, 3'b000});
    bits = 7'd8 << size;
    // push the access to the top, then shift back to fill the upper bits
    shamt = bits >= 7'(XLEN) ? 7'd0 : 7'(XLEN) - bits;
    pack = raw << shamt;
    sext = $signed(pack) >>> shamt;
    load = zext ? pack >> shamt : sext;
    {strb1, strb0} = strb;
    {wdata1, wdata0} = wshift;
  end
endmodule

// File: rtl/lsu_dat_align_unit.sv
// lsu_dat_align_unit: aligns core load/store requests onto an XLEN-wide strobed bus.
// Define LSU_MISALIGN_SPLIT_EN to split boundary-crossing accesses into two beats; otherwise misaligned accesses fault.
module lsu_dat_align_unit
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ADDR_W = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_we,
  input  logic [FUNCT3_WIDTH-1:0] i_req_funct3,
  input  logic [ADDR_W-1:0]       i_req_addr,
  input  logic [XLEN-1:0]         i_req_wdata,
  output logic                    o_bus_valid,
  input  logic                    i_bus_ready,
  output logic                    o_bus_we,
  output logic [ADDR_W-1:0]       o_bus_addr,
  output logic [XLEN-1:0]         o_bus_wdata,
  output logic [XLEN/8-1:0]       o_bus_strb,
  input  logic                    i_bus_rvalid,
  input  logic [XLEN-1:0]         i_bus_rdata,
  output logic                    o_rsp_valid,
  output logic [XLEN-1:0]         o_rsp_rdata,
  output logic                    o_rsp_err
);
  localparam int STRB_W = XLEN/8;
  localparam int OFF_W = $clog2(STRB_W);
  state_e state, state_nx;
  logic [FUNCT3_WIDTH-1:0] funct3;
  logic we, req_err, err;
  logic [ADDR_W-1:0] addr, base;
  logic [XLEN-1:0] wdata, rd0, rd1, load, wdata0, wdata1;
  logic [STRB_W-1:0] strb0, strb1;

  function automatic logic bad_size(input logic [FUNCT3_WIDTH-1:0] f);
    return f[1:0] == SZ_D && (XLEN == 32 || f[2]);
  endfunction

`ifdef LSU_MISALIGN_SPLIT_EN
  logic cross;
  assign req_err = bad_size(i_req_funct3);
  assign err = bad_size(funct3);
  assign cross = ({1'b0, addr[OFF_W-1:0]} + (OFF_W+1)'(4'd1 << funct3[1:0])) > (OFF_W+1)'(STRB_W);
`else
  function automatic logic misaligned(input logic [1:0] size, input logic [OFF_W-1:0] off);
    return (off & OFF_W'((4'd1 << size) - 4'd1)) != '0;
  endfunction
  assign req_err = bad_size(i_req_funct3) || misaligned(i_req_funct3[1:0], i_req_addr[OFF_W-1:0]);
  assign err = bad_size(funct3) || misaligned(funct3[1:0], addr[OFF_W-1:0]);
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (i_req_valid) state_nx = req_err ? RESP : ISSUE0;
      ISSUE0: if (i_bus_ready) state_nx = WAIT0;
`ifdef LSU_MISALIGN_SPLIT_EN
      WAIT0:  if (i_bus_rvalid) state_nx = cross ? ISSUE1 : RESP;
      ISSUE1: if (i_bus_ready) state_nx = WAIT1;
      WAIT1:  if (i_bus_rvalid) state_nx = RESP;
`else
      WAIT0:  if (i_bus_rvalid) state_nx = RESP;
`endif
      RESP:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= IDLE;
      funct3 <= '0;
      we <= 1'b0;
      addr <= '0;
      wdata <= '0;
      rd0 <= '0;
      rd1 <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && i_req_valid) begin
        funct3 <= i_req_funct3;
        we <= i_req_we;
        addr <= i_req_addr;
        wdata <= i_req_wdata;
      end
      if (state == WAIT0 && i_bus_rvalid) rd0 <= i_bus_rdata;
      if (state == WAIT1 && i_bus_rvalid) rd1 <= i_bus_rdata;
    end

  lsu_lane_shifter #(.XLEN(XLEN)) u_shift (
    .size(funct3[1:0]),
    .zext(funct3[2]),
    .offset(addr[OFF_W-1:0]),
    .wdata(wdata),
    .rdata0(rd0),
    .rdata1(rd1),
    .strb0(strb0),
    .strb1(strb1),
    .wdata0(wdata0),
    .wdata1(wdata1),
    .load(load)
  );

  assign base = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign o_req_ready = state == IDLE;
  assign o_bus_valid = state == ISSUE0 || state == ISSUE1;
  assign o_bus_we = we;
  assign o_bus_addr = state == ISSUE1 ? base + ADDR_W'(STRB_W) : base;
  assign o_bus_wdata = state == ISSUE1 ? wdata1 : wdata0;
  assign o_bus_strb = state == ISSUE1 ? strb1 : strb0;
  assign o_rsp_valid = state == RESP;
  assign o_rsp_err = state == RESP && err;
  assign o_rsp_rdata = (state == RESP && !we && !err) ? load : '0;
endmodule

// File: doc/lsu_dat_align_unit.md
LSU_DAT_ALIGN_UNIT -- requirements
Module: lsu_dat_align_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, register/data width; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 SHALL have derived localparam STRB_W = XLEN/8.
REQ-004 SHALL have port i_clk, input, 1, single clock for all state.
REQ-005 SHALL have port i_rst, input, 1, reset; one clock, asynchronous, active-high.
REQ-006 SHALL have request ports: i_req_valid (in, 1), o_req_ready (out, 1), i_req_we (in, 1, 1=store), i_req_funct3 (in, FUNCT3_WIDTH), i_req_addr (in, ADDR_W), i_req_wdata (in, XLEN).
REQ-007 SHALL have bus ports: o_bus_valid (out, 1), i_bus_ready (in, 1), o_bus_we (out, 1), o_bus_addr (out, ADDR_W, STRB_W-aligned), o_bus_wdata (out, XLEN), o_bus_strb (out, STRB_W), i_bus_rvalid (in, 1, beat ack/read data), i_bus_rdata (in, XLEN).
REQ-008 SHALL have response ports: o_rsp_valid (out, 1), o_rsp_rdata (out, XLEN), o_rsp_err (out, 1).

Function
REQ-009 SHALL decode size from funct3[1:0]: 00 byte, 01 half, 10 word, 11 double; funct3[2]=1 means zero-extend on load.
REQ-010 SHALL treat size 11 with XLEN=32, and funct3[2]=1 with size 11, as illegal: no bus beat, response with o_rsp_err=1.
REQ-011 SHALL accept a request only when i_req_valid and o_req_ready are both 1; o_req_ready=1 only in IDLE.
REQ-012 SHALL capture funct3, we, addr, wdata into internal registers on acceptance; later input changes have no effect.
REQ-013 SHALL implement FSM states IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
REQ-014 SHALL transition IDLE->ISSUE0 on accepted legal request; IDLE->RESP on accepted illegal request.
REQ-015 SHALL hold o_bus_valid=1 with stable addr/we/wdata/strb in ISSUEx until i_bus_ready=1, then enter WAITx.
REQ-016 SHALL leave WAIT0 on i_bus_rvalid to ISSUE1 if access crosses a STRB_W boundary, else to RESP; WAIT1 leaves to RESP on i_bus_rvalid.
REQ-017 SHALL drive o_rsp_valid=1 for exactly one cycle in RESP, then return to IDLE; no back-pressure on response.
REQ-018 SHALL compute strobe as size mask (1,3,F,FF) shifted left by addr offset; beat0 uses bits falling within STRB_W, beat1 the remainder shifted down.
REQ-019 SHALL place store data shifted left by 8*offset in beat0, remaining upper bytes at lane 0 in beat1.
REQ-020 SHALL extract load bytes from lane offset (beat0 low part, beat1 high part merged), then sign- or zero-extend to XLEN.
REQ-021 SHALL drive bus address as addr with low log2(STRB_W) bits cleared in beat0 and that value + STRB_W in beat1 (wraps modulo 2^ADDR_W).
REQ-022 SHALL ignore i_bus_rvalid outside WAITx; a simultaneous i_bus_ready and i_bus_rvalid in ISSUEx SHALL not count as the ack.
REQ-023 SHALL hold o_rsp_rdata at 0 for stores and errors.
REQ-024 SHALL give minimum latency acceptance-to-o_rsp_valid of 3 cycles for single-beat accesses, 5 for split ones, with zero-wait bus.

Reset
REQ-025 SHALL, on i_rst=1, asynchronously force state IDLE, all captured registers 0, o_bus_valid=0, o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0, o_req_ready=1.
REQ-026 SHALL abandon any in-flight access on reset mid-operation; no response is produced for it.

Configuration
REQ-027 SHALL provide macro LSU_MISALIGN_SPLIT_EN: defined = boundary-crossing accesses split into two beats per REQ-016..021.
REQ-028 SHALL, with LSU_MISALIGN_SPLIT_EN undefined, respond to any access not naturally aligned to its size with o_rsp_err=1 and no bus beat; ISSUE1/WAIT1 not synthesised.

Structure
REQ-029 SHALL place size enum, FSM state typedef and a size-to-mask function in rv32i_pkg; FUNCT3_WIDTH reused from rv32i_pkg.
REQ-030 SHALL instantiate one combinational sub-module lsu_lane_shifter (store shift/strobe and load extract/extend).

Verification
REQ-031 SHALL cover LW addr 0x104, rdata 0xDEADBEEF -> one beat, addr 0x104, strb 0xF, rsp 0xDEADBEEF.
REQ-032 SHALL cover SB addr 0x103, wdata 0x000000A5 -> strb 0x8, wdata[31:24]=0xA5.
REQ-033 SHALL cover LH/LHU addr 0x102, rdata 0x8001_1234 -> 0xFFFF8001 / 0x00008001.
REQ-034 SHALL cover LW addr 0x103, rdata 0xAA000000 then 0x00DDCCBB -> beats 0x100, 0x104, rsp 0xDDCCBBAA with macro; o_rsp_err=1, no beat without.
REQ-035 SHALL cover i_rst pulse in WAIT0 -> o_bus_valid=0 immediately, no o_rsp_valid, o_req_ready=1 after release.
REQ-036 SHALL cover XLEN=64 LD addr 0x10 -> strb 0xFF, full rdata; LD with XLEN=32 -> o_rsp_err=1.
